// File: rtl/conv_window_feeder.sv
// Sliding-window operand feeder: walks every valid output position of an image,
// reads the matching image patch and kernel taps, and streams them as pairs.
module conv_window_feeder #(
    parameter int MAX_MACS   = 64,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] img_row,
    input  logic [ADDR_WIDTH-1:0] img_col,
    input  logic [ADDR_WIDTH-1:0] ker_row,
    input  logic [ADDR_WIDTH-1:0] ker_col,
    input  logic [ADDR_WIDTH-1:0] img_base,
    input  logic [ADDR_WIDTH-1:0] ker_base,
    output logic                  img_rd_en,
    output logic                  ker_rd_en,
    output logic [ADDR_WIDTH-1:0] img_addr,
    output logic [ADDR_WIDTH-1:0] ker_addr,
    input  logic [DATA_WIDTH-1:0] img_rdata,
    input  logic [DATA_WIDTH-1:0] ker_rdata,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  win_last,
    output logic [ADDR_WIDTH-1:0] win_row,
    output logic [ADDR_WIDTH-1:0] win_col,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    localparam int AW = ADDR_WIDTH;
    localparam int PW = 2 * ADDR_WIDTH;
    localparam int EW = 2 * DATA_WIDTH + 1 + 2 * ADDR_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] img_col_q, ker_row_q, ker_col_q, img_base_q, ker_base_q;
    logic [AW-1:0] out_row_q, out_col_q;
    logic [AW-1:0] cur_row, cur_col, tap_i, tap_j;

    logic          rd_vld_p1, last_p1;
    logic [AW-1:0] row_p1, col_p1;

    logic [EW-1:0] fifo0, fifo1;
    logic [1:0]    fifo_cnt, fifo_cnt_next;

    logic          issue, push, pop, cfg_bad;
    logic          tap_j_end, tap_i_end, col_end, row_end, last_tap, last_win;
    logic [2:0]    occupancy;
    logic [PW-1:0] req_macs, img_prod, ker_prod;
    logic [AW-1:0] row_sum, col_sum;
    logic [EW-1:0] push_word;

    assign req_macs = {{AW{1'b0}}, ker_row} * {{AW{1'b0}}, ker_col};
    assign cfg_bad  = (ker_row == '0) || (ker_col == '0) ||
                      (ker_row > img_row) || (ker_col > img_col) ||
                      (req_macs > PW'(MAX_MACS));

    assign pop       = out_valid && out_ready;
    assign push      = rd_vld_p1;
    // Count the read already in flight so its data always has a slot to land in.
    assign occupancy = {1'b0, fifo_cnt} + {2'b00, rd_vld_p1} - {2'b00, pop};
    assign issue     = (state == S_RUN) && (occupancy < 3'd2);

    assign tap_j_end = (tap_j == ker_col_q - 1'b1);
    assign tap_i_end = (tap_i == ker_row_q - 1'b1);
    assign col_end   = (cur_col == out_col_q - 1'b1);
    assign row_end   = (cur_row == out_row_q - 1'b1);
    assign last_tap  = tap_i_end && tap_j_end;
    assign last_win  = row_end && col_end;

    assign row_sum  = cur_row + tap_i;
    assign col_sum  = cur_col + tap_j;
    assign img_prod = {{AW{1'b0}}, row_sum} * {{AW{1'b0}}, img_col_q};
    assign ker_prod = {{AW{1'b0}}, tap_i} * {{AW{1'b0}}, ker_col_q};

    assign img_rd_en = issue;
    assign ker_rd_en = issue;
    assign img_addr  = img_base_q + img_prod[AW-1:0] + col_sum;
    assign ker_addr  = ker_base_q + ker_prod[AW-1:0] + tap_j;

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    always_comb begin
        fifo_cnt_next = fifo_cnt;
        if (push && !pop)
            fifo_cnt_next = fifo_cnt + 2'd1;
        else if (!push && pop)
            fifo_cnt_next = fifo_cnt - 2'd1;
    end

    // Stage p0: control FSM, latched shape and traversal counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cfg_err    <= 1'b0;
            img_col_q  <= '0;
            ker_row_q  <= '0;
            ker_col_q  <= '0;
            img_base_q <= '0;
            ker_base_q <= '0;
            out_row_q  <= '0;
            out_col_q  <= '0;
            cur_row    <= '0;
            cur_col    <= '0;
            tap_i      <= '0;
            tap_j      <= '0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            state      <= S_RUN;
                            img_col_q  <= img_col;
                            ker_row_q  <= ker_row;
                            ker_col_q  <= ker_col;
                            img_base_q <= img_base;
                            ker_base_q <= ker_base;
                            out_row_q  <= img_row - ker_row + 1'b1;
                            out_col_q  <= img_col - ker_col + 1'b1;
                            cur_row    <= '0;
                            cur_col    <= '0;
                            tap_i      <= '0;
                            tap_j      <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        if (last_tap && last_win)
                            state <= S_DRAIN;
                        if (!tap_j_end) begin
                            tap_j <= tap_j + 1'b1;
                        end else begin
                            tap_j <= '0;
                            if (!tap_i_end) begin
                                tap_i <= tap_i + 1'b1;
                            end else begin
                                tap_i <= '0;
                                if (!col_end) begin
                                    cur_col <= cur_col + 1'b1;
                                end else begin
                                    cur_col <= '0;
                                    cur_row <= row_end ? '0 : cur_row + 1'b1;
                                end
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (fifo_cnt_next == 2'd0)
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stage p1: tag of the read in flight, aligned with BRAM read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_p1 <= 1'b0;
            last_p1   <= 1'b0;
            row_p1    <= '0;
            col_p1    <= '0;
        end else begin
            rd_vld_p1 <= issue;
            if (issue) begin
                last_p1 <= last_tap;
                row_p1  <= cur_row;
                col_p1  <= cur_col;
            end
        end
    end

    assign push_word = {img_rdata, ker_rdata, last_p1, row_p1, col_p1};

    // Stage p2: two-entry output FIFO, head entry drives the stream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo0    <= '0;
            fifo1    <= '0;
            fifo_cnt <= 2'd0;
        end else begin
            fifo_cnt <= fifo_cnt_next;
            if (push && !pop) begin
                if (fifo_cnt == 2'd0)
                    fifo0 <= push_word;
                else
                    fifo1 <= push_word;
            end else if (!push && pop) begin
                fifo0 <= fifo1;
            end else if (push && pop) begin
                if (fifo_cnt == 2'd1) begin
                    fifo0 <= push_word;
                end else begin
                    fifo0 <= fifo1;
                    fifo1 <= push_word;
                end
            end
        end
    end

    assign out_valid = (fifo_cnt != 2'd0);
    assign {data_out, weight_out, win_last, win_row, win_col} = fifo0;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Randomized bench for conv_window_feeder: BRAM models plus a queue-based
// reference of the expected read addresses and operand stream.
module tb_conv_window_feeder;

    localparam int AW    = 13;
    localparam int DW    = 8;
    localparam int MEMSZ = 8192;

    typedef logic [2*DW+1+2*AW-1:0] beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] img_row, img_col, ker_row, ker_col, img_base, ker_base;
    logic          img_rd_en, ker_rd_en;
    logic [AW-1:0] img_addr, ker_addr;
    logic [DW-1:0] img_rdata, ker_rdata, data_out, weight_out;
    logic          out_valid, out_ready, win_last;
    logic [AW-1:0] win_row, win_col;
    logic          busy, done, cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] img_mem [MEMSZ];
    logic [DW-1:0] ker_mem [MEMSZ];
    logic [DW-1:0] obs_data[$];
    logic [DW-1:0] obs_wt[$];

    conv_window_feeder #(.MAX_MACS(64), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .img_row(img_row), .img_col(img_col), .ker_row(ker_row), .ker_col(ker_col),
        .img_base(img_base), .ker_base(ker_base),
        .img_rd_en(img_rd_en), .ker_rd_en(ker_rd_en),
        .img_addr(img_addr), .ker_addr(ker_addr),
        .img_rdata(img_rdata), .ker_rdata(ker_rdata),
        .data_out(data_out), .weight_out(weight_out),
        .out_valid(out_valid), .out_ready(out_ready), .win_last(win_last),
        .win_row(win_row), .win_col(win_col),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (img_rd_en) img_rdata <= img_mem[img_addr];
        if (ker_rd_en) ker_rdata <= ker_mem[ker_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctl"}, {img_rd_en, ker_rd_en, out_valid, win_last, busy, done, cfg_err}, 0);
        chk({tag, "_addr"}, {img_addr, ker_addr, win_row, win_col}, 0);
        chk({tag, "_data"}, {data_out, weight_out}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk_outputs_zero("rst_mid");
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_outputs_zero("rst_hold");
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
    endtask

    task automatic run_job(input int ir, input int ic, input int kr, input int kc,
                           input int ib, input int kb, input int ready_pct,
                           input int restart_at, input int reset_at);
        beat_t             exp_q[$];
        logic [2*AW-1:0]   addr_q[$];
        logic [2*AW-1:0]   exp_addr;
        beat_t             exp_beat, cur, prev_beat;
        int orr, occ, total, ia, ka;
        int n_x, n_last, issued, done_k;
        bit prev_valid, prev_x, prev_final;

        orr = ir - kr + 1;
        occ = ic - kc + 1;
        total = orr * occ * kr * kc;
        for (int r = 0; r < orr; r++)
            for (int c = 0; c < occ; c++)
                for (int i = 0; i < kr; i++)
                    for (int j = 0; j < kc; j++) begin
                        ia = (ib + (r + i) * ic + c + j) % MEMSZ;
                        ka = (kb + i * kc + j) % MEMSZ;
                        addr_q.push_back({AW'(ia), AW'(ka)});
                        exp_q.push_back({img_mem[ia], ker_mem[ka],
                                         1'(i == kr - 1 && j == kc - 1), AW'(r), AW'(c)});
                    end
        obs_data.delete();
        obs_wt.delete();
        n_x = 0; n_last = 0; issued = 0; done_k = 0;
        prev_valid = 0; prev_x = 0; prev_final = 0; prev_beat = '0;

        @(negedge clk);
        img_row = AW'(ir); img_col = AW'(ic); ker_row = AW'(kr); ker_col = AW'(kc);
        img_base = AW'(ib); ker_base = AW'(kb);
        start = 1'b1;
        out_ready = 1'b1;

        for (int k = 1; k <= 4000 && done_k == 0; k++) begin
            @(negedge clk);
            start = (k == restart_at);
            out_ready = ($urandom_range(99) < ready_pct);
            #1;
            cur = {data_out, weight_out, win_last, win_row, win_col};
            chk("rd_en_pair", img_rd_en, ker_rd_en);
            chk("cfg_err_run", cfg_err, 0);
            if (k == 1) begin
                chk("busy_t1", busy, 1);
                chk("rd_en_t1", img_rd_en, 1);
                chk("valid_t1", out_valid, 0);
            end
            if (k == 2) chk("valid_t2", out_valid, 0);
            if (k == 3) chk("valid_t3", out_valid, 1);
            chk("done", done, prev_final);
            chk("busy", busy, !prev_final);
            if (done) done_k = k;
            if (prev_valid && !prev_x) chk("stall_hold", {out_valid, cur}, {1'b1, prev_beat});
            if (img_rd_en) begin
                if (addr_q.size() == 0) begin
                    chk("extra_read", 1, 0);
                end else begin
                    exp_addr = addr_q.pop_front();
                    chk("rd_addr", {img_addr, ker_addr}, exp_addr);
                end
                issued++;
            end
            prev_final = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_xfer", 1, 0);
                end else begin
                    exp_beat = exp_q.pop_front();
                    chk("xfer", cur, exp_beat);
                end
                obs_data.push_back(data_out);
                obs_wt.push_back(weight_out);
                if (win_last) n_last++;
                n_x++;
                prev_final = (n_x == total);
            end
            chk("outstanding_le2", ((issued - n_x) <= 2), 1);
            prev_valid = out_valid;
            prev_x     = out_valid && out_ready;
            prev_beat  = cur;
            if (reset_at > 0 && n_x == reset_at) begin
                do_reset();
                return;
            end
        end
        chk("done_seen", (done_k != 0), 1);
        chk("n_xfer", n_x, total);
        chk("n_last", n_last, orr * occ);
        if (ready_pct >= 100) chk("no_bubbles", done_k, total + 3);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("done_single", done, 0);
        chk("busy_after", busy, 0);
    endtask

    task automatic bad_start(input string tag, input int ir, input int ic, input int kr, input int kc);
        @(negedge clk);
        img_row = AW'(ir); img_col = AW'(ic); ker_row = AW'(kr); ker_col = AW'(kc);
        img_base = '0; ker_base = AW'(16);
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({tag, "_cfg_err"}, cfg_err, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd_en"}, img_rd_en, 0);
        @(negedge clk);
        #1;
        chk({tag, "_cfg_err_drop"}, cfg_err, 0);
        chk({tag, "_idle"}, {busy, img_rd_en, out_valid}, 0);
    endtask

    initial begin
        int w0[4];
        int ir, ic, kr, kc;
        w0 = '{0, 1, 3, 4};
        for (int a = 0; a < MEMSZ; a++) begin
            img_mem[a] = 8'(a);
            ker_mem[a] = 8'(a + 84);
        end
        rst = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        img_row = '0; img_col = '0; ker_row = '0; ker_col = '0;
        img_base = '0; ker_base = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_outputs_zero("rst_init");
        @(negedge clk);
        rst = 1'b1;

        run_job(3, 3, 2, 2, 0, 16, 100, 0, 0);
        for (int t = 0; t < 4; t++) begin
            chk("win0_data", obs_data[t], 8'(w0[t]));
            chk("win0_weight", obs_wt[t], 8'(100 + t));
        end

        run_job(3, 3, 2, 2, 0, 16, 50, 0, 0);

        run_job(4, 5, 1, 1, 0, 16, 100, 0, 0);
        for (int t = 0; t < 20; t++) chk("k1x1_data", obs_data[t], 8'(t));

        bad_start("ker_row0", 3, 3, 0, 2);
        bad_start("ker_too_tall", 3, 3, 4, 2);
        bad_start("ker_too_big", 10, 10, 9, 8);

        run_job(8, 8, 8, 8, 0, 16, 100, 0, 0);

        run_job(3, 3, 2, 2, 0, 16, 100, 0, 7);
        run_job(3, 3, 2, 2, 0, 16, 100, 0, 0);

        run_job(3, 3, 2, 2, 0, 16, 100, 5, 0);

        for (int a = 0; a < MEMSZ; a++) begin
            img_mem[a] = 8'($urandom);
            ker_mem[a] = 8'($urandom);
        end
        for (int n = 0; n < 10; n++) begin
            ir = $urandom_range(6, 1);
            ic = $urandom_range(6, 1);
            kr = $urandom_range((ir < 4) ? ir : 4, 1);
            kc = $urandom_range((ic < 4) ? ic : 4, 1);
            run_job(ir, ic, kr, kc, $urandom_range(MEMSZ - 1, MEMSZ - 40),
                    $urandom_range(MEMSZ - 1, 0), 50, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
